// File: rtl/led_pkg.sv
// Shared types and helpers for the LED matrix scanner.
// Scan FSM states plus a one-hot row-select builder.
package led_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_BLANK = 2'd2
    } scan_state_t;

    // Widest array row_sel can describe; callers truncate to their own N.
    localparam int MAX_ROWS = 64;

    function automatic logic [MAX_ROWS-1:0] row_sel(input int n, input int idx);
        logic [MAX_ROWS-1:0] sel;
        sel = '0;
        if (idx >= 0 && idx < n && idx < MAX_ROWS) begin
            sel = {{(MAX_ROWS-1){1'b0}}, 1'b1} << idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pulse_divider.sv
// Free-running divider: tick is high for one clk every display_divider cycles.
// With display_divider = 1 the tick is permanently high.
module pulse_divider #(
    parameter int display_divider = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (display_divider > 1) ? $clog2(display_divider) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(display_divider - 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == LAST_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed N x N LED scanner with a shadow frame buffer loaded only at the
// frame wrap. Define LED_BLANKING_EN to insert one blank tick after every lit row.
module led_matrix_scanner
    import led_pkg::*;
#(
    parameter int N               = 15,
    parameter int display_divider = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*N-1:0]       cells,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    output logic [N-1:0]         rows,
    output logic [N-1:0]         cols,
    output logic [$clog2(N)-1:0] row_index,
    output logic                 frame_done
);

    localparam int RW = $clog2(N);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam logic [N-1:0]  ROW0_SEL = N'(1);

    scan_state_t      state_reg;
    logic [RW-1:0]    row_index_reg;
    logic [N-1:0]     rows_reg;
    logic [N-1:0]     cols_reg;
    logic             frame_done_reg;
    logic [N*N-1:0]   shadow_reg;

    logic             tick;
    logic             last_row;
    logic             transfer;
    logic [RW-1:0]    next_row;
    logic [N-1:0]     shadow_rows [N];

    pulse_divider #(
        .display_divider(display_divider)
    ) u_divider (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rows
            assign shadow_rows[gi] = shadow_reg[gi*N +: N];
        end
    endgenerate

    // Explicit wrap keeps row_index inside 0..N-1 for non power-of-2 N.
    assign last_row    = (row_index_reg == LAST_ROW);
    assign next_row    = last_row ? '0 : row_index_reg + 1'b1;
    assign frame_ready = (state_reg == S_IDLE) ||
                         ((state_reg == S_SCAN) && tick && last_row);
    assign transfer    = frame_valid && frame_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            row_index_reg  <= '0;
            rows_reg       <= '0;
            cols_reg       <= '1;
            frame_done_reg <= 1'b0;
            shadow_reg     <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    rows_reg <= '0;
                    cols_reg <= '1;
                    if (transfer) begin
                        // Shadow is written this edge, so row 0 comes straight from cells.
                        shadow_reg    <= cells;
                        row_index_reg <= '0;
                        rows_reg      <= ROW0_SEL;
                        cols_reg      <= ~cells[N-1:0];
                        state_reg     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (tick) begin
                        row_index_reg <= next_row;
                        if (last_row) begin
                            frame_done_reg <= 1'b1;
                        end
                        if (transfer) begin
                            shadow_reg <= cells;
                        end
`ifdef LED_BLANKING_EN
                        state_reg <= S_BLANK;
                        rows_reg  <= '0;
                        cols_reg  <= '1;
`else
                        rows_reg <= N'(row_sel(N, int'(next_row)));
                        cols_reg <= (last_row && transfer) ? ~cells[N-1:0]
                                                           : ~shadow_rows[next_row];
`endif
                    end
                end
                S_BLANK: begin
`ifdef LED_BLANKING_EN
                    // row_index already points at the row to light after the gap.
                    if (tick) begin
                        state_reg <= S_SCAN;
                        rows_reg  <= N'(row_sel(N, int'(row_index_reg)));
                        cols_reg  <= ~shadow_rows[row_index_reg];
                    end
`else
                    state_reg <= S_IDLE;
                    rows_reg  <= '0;
                    cols_reg  <= '1;
`endif
                end
                default: begin
                    state_reg <= S_IDLE;
                    rows_reg  <= '0;
                    cols_reg  <= '1;
                end
            endcase
        end
    end

    assign rows       = rows_reg;
    assign cols       = cols_reg;
    assign row_index  = row_index_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: a divide-by-1 instance for picture and
// handshake checks and a divide-by-4 instance for tick timing.
module tb_led_matrix_scanner;

    localparam int N = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*N-1:0] cells, cells4;
    logic           frame_valid, frame_valid4;
    logic           frame_ready, frame_ready4;
    logic [N-1:0]   rows, cols, rows4, cols4;
    logic [3:0]     row_index, row_index4;
    logic           frame_done, frame_done4;

    int errors = 0;
    int checks = 0;

    logic [N*N-1:0] frame_a;
    logic [N*N-1:0] frame_b;

    always #5 clk = ~clk;

    led_matrix_scanner #(.N(N), .display_divider(1)) dut (
        .clk(clk), .rst(rst), .cells(cells), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .rows(rows), .cols(cols),
        .row_index(row_index), .frame_done(frame_done)
    );

    led_matrix_scanner #(.N(N), .display_divider(4)) dut4 (
        .clk(clk), .rst(rst), .cells(cells4), .frame_valid(frame_valid4),
        .frame_ready(frame_ready4), .rows(rows4), .cols(cols4),
        .row_index(row_index4), .frame_done(frame_done4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int cnt;
        int adv;
        bit seen;

        frame_a = '0;
        frame_a[0]   = 1'b1;   // (0,0)
        frame_a[108] = 1'b1;   // (7,3)
        frame_a[224] = 1'b1;   // (14,14)
        frame_b = '0;
        frame_b[7:4] = 4'hF;   // row 0, cols 4..7

        rst = 1'b1; cells = '0; frame_valid = 1'b0; cells4 = '0; frame_valid4 = 1'b0;
        repeat (2) step();
        check("reset_rows", 32'(rows), 32'h0);
        check("reset_cols", 32'(cols), 32'h7FFF);
        check("reset_ready", 32'(frame_ready), 32'h1);
        check("reset_done", 32'(frame_done), 32'h0);
        check("reset_row_index", 32'(row_index), 32'h0);

        rst = 1'b0;
        cells = frame_a; frame_valid = 1'b1;
        check("idle_ready", 32'(frame_ready), 32'h1);
        step();
        // Hold the next frame offered for the whole scan.
        cells = frame_b; frame_valid = 1'b1;
        check("row0_rows", 32'(rows), 32'h0001);
        check("row0_cols", 32'(cols), 32'h7FFE);
        check("row0_ready_low", 32'(frame_ready), 32'h0);
        check("row0_done", 32'(frame_done), 32'h0);

        repeat (7) step();
        check("row7_index", 32'(row_index), 32'd7);
        check("row7_rows", 32'(rows), 32'h0080);
        check("row7_cols_old_frame", 32'(cols), 32'h7FF7);
        check("row7_ready_backpressure", 32'(frame_ready), 32'h0);

        repeat (7) step();
        check("row14_rows", 32'(rows), 32'h4000);
        check("row14_cols", 32'(cols), 32'h3FFF);
        check("row14_ready", 32'(frame_ready), 32'h1);
        check("row14_done", 32'(frame_done), 32'h0);

        step();
        frame_valid = 1'b0;
        check("wrap_rows", 32'(rows), 32'h0001);
        check("wrap_new_frame_cols", 32'(cols), 32'h7F0F);
        check("wrap_done_pulse", 32'(frame_done), 32'h1);
        check("wrap_row_index", 32'(row_index), 32'h0);

        pulses = 0;
        repeat (14) begin
            step();
            if (frame_done) pulses++;
        end
        check("no_done_midframe", 32'(pulses), 32'd0);
        step();
        check("rescan_done_pulse", 32'(frame_done), 32'h1);
        check("rescan_same_cols", 32'(cols), 32'h7F0F);

        repeat (7) step();
        check("pre_reset_row7", 32'(row_index), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_rows", 32'(rows), 32'h0);
        check("midreset_cols", 32'(cols), 32'h7FFF);
        check("midreset_done", 32'(frame_done), 32'h0);
        check("midreset_ready", 32'(frame_ready), 32'h1);
        step();
        check("after_reset_idle_rows", 32'(rows), 32'h0);
        check("after_reset_idle_done", 32'(frame_done), 32'h0);

        cells4 = frame_a; frame_valid4 = 1'b1;
        step();
        frame_valid4 = 1'b0;
        check("div4_row0_rows", 32'(rows4), 32'h0001);
        check("div4_row0_cols", 32'(cols4), 32'h7FFE);

        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (frame_done4) seen = 1'b1;
        end
        check("div4_done_seen", 32'(seen), 32'h1);

        cnt = 0; adv = 0; seen = 1'b0;
        while (cnt < 100 && !seen) begin
            step();
            cnt++;
            if (row_index4 == 4'd1 && adv == 0) adv = cnt;
            if (frame_done4) seen = 1'b1;
        end
        check("div4_row_advance_clk", 32'(adv), 32'd4);
        check("div4_done_period_clk", 32'(cnt), 32'd60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
